// File: rtl/psg_wave_fetch.sv
// psg_wave_fetch: system-side bus-cycle engine of the PSG wave-table arbiter
// tree. Runs the granted channel's read on the system bus, returns the sample
// with a one-hot data-valid pulse, and tells the arbiter when the bus is free.
// A cycle counter aborts stalled reads so the arbitration tree cannot lock up.

module psg_wave_fetch #(
    parameter int ADDR_W  = 24,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce,
    input  logic [7:0]            req,
    input  logic [7:0]            sel,
    input  logic [2:0]            seln,
    input  logic [8*ADDR_W-1:0]   adr_ch,
    output logic                  arb_ack,
    output logic                  cyc_o,
    output logic                  stb_o,
    output logic                  we_o,
    output logic [ADDR_W-1:0]     adr_o,
    input  logic [DATA_W-1:0]     dat_i,
    input  logic                  ack_i,
    output logic [DATA_W-1:0]     dat_o,
    output logic [7:0]            dv,
    output logic                  err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Last counter value allowed before the bus cycle is abandoned.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t              state;
    state_t              state_nxt;
    logic                upd;
    logic [2:0]          chan;
    logic [7:0]          cnt;
    logic                cyc;
    logic                err_q;
    logic                launch;
    logic                bus_ack;
    logic                bus_to;
    logic [ADDR_W-1:0]   adr_sel;

    // Address of the channel currently named by the arbiter.
    always_comb begin
        adr_sel = '0;
        for (int n = 0; n < 8; n++) begin
            if (seln == 3'(n)) begin
                adr_sel = adr_ch[n*ADDR_W +: ADDR_W];
            end
        end
    end

    // Next-state decode; ack_i wins over the timeout when both happen together.
    always_comb begin
        state_nxt = state;
        arb_ack   = 1'b0;
        launch    = 1'b0;
        bus_ack   = 1'b0;
        bus_to    = 1'b0;
        case (state)
            IDLE: begin
                arb_ack = 1'b1;
                // upd marks that sel/seln were refreshed at the previous edge
                if (upd && (sel != 8'd0) && req[seln]) begin
                    launch    = 1'b1;
                    state_nxt = BUS;
                end
            end
            BUS: begin
                if (ack_i) begin
                    bus_ack   = 1'b1;
                    state_nxt = DONE;
                end else if (cnt == TO_LAST) begin
                    bus_to    = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Control registers: arbiter-update flag, owning channel, wait counter, bus cycle, error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            upd   <= 1'b0;
            chan  <= 3'd0;
            cnt   <= 8'd0;
            cyc   <= 1'b0;
            err_q <= 1'b0;
        end else begin
            upd <= ce & arb_ack;
            if (launch) begin
                chan <= seln;
                cnt  <= 8'd0;
                cyc  <= 1'b1;
            end else if (state == BUS) begin
                if (bus_ack || bus_to) begin
                    cyc   <= 1'b0;
                    err_q <= bus_to;
                end else begin
                    cnt <= cnt + 8'd1;
                end
            end
        end
    end

    // Bus address and returned sample; dat_o holds until the next completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            adr_o <= '0;
            dat_o <= '0;
        end else begin
            if (launch) begin
                adr_o <= adr_sel;
            end
            if (bus_ack) begin
                dat_o <= dat_i;
            end else if (bus_to) begin
                dat_o <= '0;
            end
        end
    end

    assign cyc_o = cyc;
    assign stb_o = cyc;
    assign we_o  = 1'b0;
    assign dv    = (state == DONE) ? (8'd1 << chan) : 8'd0;
    assign err   = (state == DONE) & err_q;

endmodule

// File: doc/psg_wave_fetch.md
# psg_wave_fetch

Bus-cycle engine at the system side of the PSG wave-table arbiter tree. The arbiter grants one of eight wave-table channels; this block performs the granted channel's read on the system bus and returns the sample to that channel. It also generates the `ack` the arbiter uses to decide when it may re-arbitrate. A timeout aborts stalled bus cycles so that the arbitration tree cannot lock up.

## Interface
- `ADDR_W`, 24: system bus / wave-table address width.
- `DATA_W`, 16: sample width.
- `TIMEOUT`, 255: maximum BUS-state cycles without `ack_i` before abort; legal range 1..255.

Ports:
- `clk  in  1`: system clock, e.g. 100 MHz.
- `rst  in  1`: synchronous, active-high reset.
- `ce  in  1`: arbiter clock enable, e.g. 25 MHz; the same signal that drives the arbiter.
- `req  in  8`: channel request vector; the same signals that feed the arbiter.
- `sel  in  8`: one-hot grant from the arbiter.
- `seln  in  3`: index of the granted channel, from the arbiter.
- `adr_ch  in  8*ADDR_W`: per-channel fetch address; channel n is at `[n*ADDR_W +: ADDR_W]`.
- `arb_ack  out  1`: goes to the arbiter `ack` input. High means the bus is free.
- `cyc_o  out  1`: system bus cycle valid.
- `stb_o  out  1`: system bus strobe.
- `we_o  out  1`: constant 0 (read-only).
- `adr_o  out  ADDR_W`: system bus address.
- `dat_i  in  DATA_W`: system bus read data.
- `ack_i  in  1`: system bus acknowledge.
- `dat_o  out  DATA_W`: returned sample. It is shared by all channels and valid when `dv` has any bit set.
- `dv  out  8`: one-hot, one-cycle data-valid pulse to the owning channel.
- `err  out  1`: one-cycle pulse coincident with `dv`, asserted when the cycle timed out.

## Operation
- States: IDLE, BUS, DONE.
- Internal register `upd` is loaded with `ce & arb_ack` every clock. It flags that the arbiter updated `sel` at the previous edge.
- IDLE:
  - `arb_ack=1`, `cyc_o=stb_o=0`.
  - Launch when `upd=1`, `sel!=0`, and `req[seln]=1`. At the launch edge:
    - latch `chan<=seln` and `adr_o<=adr_ch[chan]`;
    - set `cyc_o=stb_o=1` and `arb_ack=0`;
    - clear the timeout counter;
    - go to BUS.
  - Otherwise stay in IDLE.
- BUS:
  - `arb_ack=0`. The counter increments each cycle that `ack_i=0`.
  - On `ack_i=1`: `dat_o<=dat_i`, `cyc_o=stb_o<=0`, go to DONE with `err<=0`.
  - Else, when the counter equals `TIMEOUT-1`: `dat_o<=0`, `cyc_o=stb_o<=0`, go to DONE with `err<=1`.
  - `ack_i` takes priority if it arrives in the timeout cycle.
- DONE (one cycle):
  - `dv[chan]=1`; `err` as set on entry; `arb_ack=0`.
  - Go to IDLE.
- `chan` is used for `dv` even if the arbiter changes `sel` or `seln` during BUS. `sel`, `seln` and `req` are ignored outside IDLE.
- `ack_i` is ignored in IDLE and DONE.
- A requester drops `req` on the edge after its `dv`. Because `arb_ack=0` through BUS and DONE, the first `upd=1` after returning to IDLE reflects the updated requests.
- Reset: every output goes to 0 except `arb_ack=1`. State is IDLE, and `upd`, `chan` and the counter are 0. Reset during BUS drops `cyc_o/stb_o` at that edge and produces no `dv` or `err`.

## Timing
- Launch: one cycle after the `ce & arb_ack` edge that updated `sel`.
- `cyc_o` is high from the launch edge until the edge that samples `ack_i=1` or hits timeout.
- With zero-wait-state `ack_i` (high in the first BUS cycle): BUS lasts 1 cycle and DONE 1 cycle, then IDLE.
  - `arb_ack` is low for exactly 2 cycles.
  - Back-to-back grants with `ce` tied high occur every 4 clocks.
- Timeout: BUS lasts exactly `TIMEOUT` cycles.
- `dat_o` holds its value until the next DONE.

## Test plan
- Reset with `ce=1`, `req=0` → `arb_ack=1`, `cyc_o=0`, `dv=0`, `adr_o=0`. Assert `rst` for 1 cycle mid-BUS → `cyc_o=0` next cycle, no `dv`.
- `ce=1` constant, `req=8'h04`, `adr_ch[2]=24'h001230`, `ack_i` 2 cycles after `cyc_o`, `dat_i=16'hBEEF` → `adr_o=24'h001230`, then `dv=8'h04`, `dat_o=16'hBEEF`, `err=0`, and `arb_ack` low for 4 cycles.
- `ce` high one cycle in four, `req=8'h81`, requesters drop `req` after `dv` → channel 0 served first (`dv=8'h01`), then channel 7 (`dv=8'h80`) with address `adr_ch[7]`.
- `TIMEOUT=8`, `req=8'h20`, `ack_i` never asserts → `cyc_o` high exactly 8 cycles, then `dv=8'h20`, `err=1`, `dat_o=0`.
- `ack_i` in the same cycle the counter reaches `TIMEOUT-1`, `dat_i=16'h1234` → `err=0`, `dat_o=16'h1234`.
- During BUS for channel 3, the arbiter changes `seln` to 5 → `dv=8'h08` (channel 3 only). Stray `ack_i` pulses in IDLE produce no `dv`.
